// File: rtl/uart2spi_cfg_ctrl.sv
// Configuration sequencer for the uart2spi bridge: power-on defaults, safe host
// reconfiguration (quiesce / apply / settle) and error-rate driven Rx/Tx recovery.
module uart2spi_cfg_ctrl #(
  parameter logic [11:0] DEF_BAUD    = 12'd26,
  parameter logic        DEF_STOP    = 1'b0,
  parameter logic [1:0]  DEF_PRI     = 2'd0,
  parameter int          QUIESCE_CYC = 16,
  parameter int          SETTLE_CYC  = 32,
  parameter int          ERR_THRESH  = 4,
  parameter int          ERR_WINDOW  = 1024
) (
  input  logic        line_clk,
  input  logic        line_reset,
  input  logic        upd_req,
  input  logic [11:0] upd_baud,
  input  logic        upd_stop,
  input  logic [1:0]  upd_pri,
  output logic        upd_ack,
  output logic        upd_rej,
  input  logic        frm_error,
  input  logic        par_error,
  input  logic        stat_clr,
  output logic        cfg_tx_enable,
  output logic        cfg_rx_enable,
  output logic        cfg_stop_bit,
  output logic [1:0]  cfg_pri_mod,
  output logic [11:0] cfg_baud_16x,
  output logic        busy,
  output logic [7:0]  frm_cnt,
  output logic [7:0]  par_cnt,
  output logic [7:0]  recov_cnt
);

  localparam int TMR_MAX = (QUIESCE_CYC > SETTLE_CYC) ? QUIESCE_CYC : SETTLE_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int WIN_W   = $clog2(ERR_WINDOW);
  localparam int ERR_W   = $clog2(ERR_THRESH + 2) + 1;

  localparam logic [TMR_W-1:0] Q_LAST   = TMR_W'(QUIESCE_CYC - 1);
  localparam logic [TMR_W-1:0] S_LAST   = TMR_W'(SETTLE_CYC - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(ERR_WINDOW - 1);
  localparam logic [ERR_W-1:0] ERR_LIM  = ERR_W'(ERR_THRESH);

  typedef enum logic [1:0] {
    ST_SETTLE  = 2'd0,
    ST_RUN     = 2'd1,
    ST_QUIESCE = 2'd2,
    ST_APPLY   = 2'd3
  } state_t;

  state_t            state_r;
  logic [TMR_W-1:0]  timer_r;
  logic              en_r;
  logic              busy_r;
  logic              upd_ack_r;
  logic              upd_rej_r;
  logic              recov_flag_r;
  logic [11:0]       baud_r;
  logic              stop_r;
  logic [1:0]        pri_r;
  logic [11:0]       sh_baud_r;
  logic              sh_stop_r;
  logic [1:0]        sh_pri_r;
  logic              frm_d_r;
  logic              par_d_r;
  logic [7:0]        frm_cnt_r;
  logic [7:0]        par_cnt_r;
  logic [7:0]        recov_cnt_r;
  logic [WIN_W-1:0]  win_cnt_r;
  logic [ERR_W-1:0]  win_err_r;

  logic              frm_edge_s;
  logic              par_edge_s;
  logic [1:0]        err_inc_s;
  logic              req_bad_s;
  logic              req_take_s;
  logic              thresh_hit_s;
  logic              recov_go_s;

  function automatic logic [7:0] sat_inc(input logic [7:0] val, input logic inc);
    logic [7:0] res;
    if (inc && (val != 8'hFF)) begin
      res = val + 8'd1;
    end else begin
      res = val;
    end
    return res;
  endfunction

  // Edge detection, request qualification and recovery decision.
  always_comb begin
    frm_edge_s   = frm_error & ~frm_d_r;
    par_edge_s   = par_error & ~par_d_r;
    err_inc_s    = {1'b0, frm_edge_s} + {1'b0, par_edge_s};
    req_bad_s    = (upd_pri == 2'd3) || (upd_baud == 12'd0);
    // The cycle showing upd_rej is the host's grace cycle to drop upd_req.
    req_take_s   = (state_r == ST_RUN) && upd_req && !upd_rej_r;
    thresh_hit_s = (win_err_r >= ERR_LIM);
    recov_go_s   = (state_r == ST_RUN) && !req_take_s && thresh_hit_s;
  end

  // Error edge registers and saturating statistics counters.
  always_ff @(posedge line_clk) begin
    if (line_reset) begin
      frm_d_r     <= 1'b0;
      par_d_r     <= 1'b0;
      frm_cnt_r   <= 8'd0;
      par_cnt_r   <= 8'd0;
      recov_cnt_r <= 8'd0;
    end else begin
      frm_d_r <= frm_error;
      par_d_r <= par_error;
      if (stat_clr) begin
        frm_cnt_r   <= 8'd0;
        par_cnt_r   <= 8'd0;
        recov_cnt_r <= 8'd0;
      end else begin
        frm_cnt_r   <= sat_inc(frm_cnt_r, frm_edge_s);
        par_cnt_r   <= sat_inc(par_cnt_r, par_edge_s);
        recov_cnt_r <= sat_inc(recov_cnt_r, recov_go_s);
      end
    end
  end

  // Error-rate window; held cleared outside RUN so each RUN entry starts fresh.
  always_ff @(posedge line_clk) begin
    if (line_reset || (state_r != ST_RUN)) begin
      win_cnt_r <= '0;
      win_err_r <= '0;
    end else if (win_cnt_r == WIN_LAST) begin
      win_cnt_r <= '0;
      win_err_r <= '0;
    end else begin
      win_cnt_r <= win_cnt_r + WIN_W'(1);
      if (win_err_r < ERR_LIM) begin
        win_err_r <= win_err_r + ERR_W'(err_inc_s);
      end
    end
  end

  // Sequencer FSM with registered enables, config and handshake pulses.
  always_ff @(posedge line_clk) begin
    if (line_reset) begin
      state_r      <= ST_SETTLE;
      timer_r      <= '0;
      en_r         <= 1'b0;
      busy_r       <= 1'b1;
      upd_ack_r    <= 1'b0;
      upd_rej_r    <= 1'b0;
      recov_flag_r <= 1'b0;
      baud_r       <= DEF_BAUD;
      stop_r       <= DEF_STOP;
      pri_r        <= DEF_PRI;
      sh_baud_r    <= DEF_BAUD;
      sh_stop_r    <= DEF_STOP;
      sh_pri_r     <= DEF_PRI;
    end else begin
      upd_ack_r <= 1'b0;
      upd_rej_r <= 1'b0;
      case (state_r)
        ST_SETTLE: begin
          if (timer_r == S_LAST) begin
            state_r <= ST_RUN;
            timer_r <= '0;
            en_r    <= 1'b1;
            busy_r  <= 1'b0;
          end else begin
            timer_r <= timer_r + TMR_W'(1);
          end
        end
        ST_RUN: begin
          if (req_take_s && req_bad_s) begin
            upd_rej_r <= 1'b1;
          end else if (req_take_s || recov_go_s) begin
            if (req_take_s) begin
              sh_baud_r <= upd_baud;
              sh_stop_r <= upd_stop;
              sh_pri_r  <= upd_pri;
            end
            recov_flag_r <= !req_take_s;
            state_r      <= ST_QUIESCE;
            timer_r      <= '0;
            en_r         <= 1'b0;
            busy_r       <= 1'b1;
          end
        end
        ST_QUIESCE: begin
          if (timer_r == Q_LAST) begin
            timer_r <= '0;
            if (recov_flag_r) begin
              state_r <= ST_SETTLE;
            end else begin
              state_r   <= ST_APPLY;
              baud_r    <= sh_baud_r;
              stop_r    <= sh_stop_r;
              pri_r     <= sh_pri_r;
              upd_ack_r <= 1'b1;
            end
          end else begin
            timer_r <= timer_r + TMR_W'(1);
          end
        end
        ST_APPLY: begin
          state_r <= ST_SETTLE;
          timer_r <= '0;
        end
        default: begin
          state_r <= ST_SETTLE;
          timer_r <= '0;
          en_r    <= 1'b0;
          busy_r  <= 1'b1;
        end
      endcase
    end
  end

  assign upd_ack       = upd_ack_r;
  assign upd_rej       = upd_rej_r;
  assign cfg_tx_enable = en_r;
  assign cfg_rx_enable = en_r;
  assign cfg_stop_bit  = stop_r;
  assign cfg_pri_mod   = pri_r;
  assign cfg_baud_16x  = baud_r;
  assign busy          = busy_r;
  assign frm_cnt       = frm_cnt_r;
  assign par_cnt       = par_cnt_r;
  assign recov_cnt     = recov_cnt_r;

endmodule

// File: tb/tb_uart2spi_cfg_ctrl.sv
// Self-checking bench for uart2spi_cfg_ctrl: a timestamp-based reference model
// compared every cycle, plus directed scenarios with hand-computed literals.
module tb_uart2spi_cfg_ctrl;

  localparam int Q = 4;
  localparam int S = 8;
  localparam int T = 4;
  localparam int W = 64;

  logic        line_clk = 1'b0;
  logic        line_reset;
  logic        upd_req;
  logic [11:0] upd_baud;
  logic        upd_stop;
  logic [1:0]  upd_pri;
  logic        upd_ack;
  logic        upd_rej;
  logic        frm_error;
  logic        par_error;
  logic        stat_clr;
  logic        cfg_tx_enable;
  logic        cfg_rx_enable;
  logic        cfg_stop_bit;
  logic [1:0]  cfg_pri_mod;
  logic [11:0] cfg_baud_16x;
  logic        busy;
  logic [7:0]  frm_cnt;
  logic [7:0]  par_cnt;
  logic [7:0]  recov_cnt;

  int checks   = 0;
  int failures = 0;

  uart2spi_cfg_ctrl #(
    .DEF_BAUD(12'd26), .DEF_STOP(1'b0), .DEF_PRI(2'd0),
    .QUIESCE_CYC(Q), .SETTLE_CYC(S), .ERR_THRESH(T), .ERR_WINDOW(W)
  ) dut (
    .line_clk(line_clk), .line_reset(line_reset),
    .upd_req(upd_req), .upd_baud(upd_baud), .upd_stop(upd_stop), .upd_pri(upd_pri),
    .upd_ack(upd_ack), .upd_rej(upd_rej),
    .frm_error(frm_error), .par_error(par_error), .stat_clr(stat_clr),
    .cfg_tx_enable(cfg_tx_enable), .cfg_rx_enable(cfg_rx_enable),
    .cfg_stop_bit(cfg_stop_bit), .cfg_pri_mod(cfg_pri_mod), .cfg_baud_16x(cfg_baud_16x),
    .busy(busy), .frm_cnt(frm_cnt), .par_cnt(par_cnt), .recov_cnt(recov_cnt)
  );

  always #5 line_clk = ~line_clk;

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: RUN is described by the edge index run_at after which the
  // block is running; every disruption just reschedules run_at / apply_at.
  int  e        = 0;
  int  run_at   = 32'h3fffffff;
  int  apply_at = -1;
  bit  m_valid  = 1'b0;
  int  m_baud, m_stop, m_pri, m_ack, m_rej, m_frm, m_par, m_rec;
  int  sh_baud, sh_stop, sh_pri;
  bit  pf, pp;
  int  win_sum;

  function automatic int sat8(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic model_step();
    int k;
    int fe, pe;
    bit was_run, go_rec, nack, nrej;
    e = e + 1;
    if (line_reset) begin
      m_valid = 1'b1; run_at = e + S; apply_at = -1;
      m_baud = 26; m_stop = 0; m_pri = 0; m_ack = 0; m_rej = 0;
      m_frm = 0; m_par = 0; m_rec = 0; pf = 1'b0; pp = 1'b0; win_sum = 0;
    end else if (m_valid) begin
      fe = (frm_error && !pf) ? 1 : 0;
      pe = (par_error && !pp) ? 1 : 0;
      was_run = (e - 1 >= run_at);
      go_rec = 1'b0;
      nrej = 1'b0;
      nack = (e == apply_at);
      if (nack) begin
        m_baud = sh_baud; m_stop = sh_stop; m_pri = sh_pri;
      end
      if (was_run) begin
        k = e - 1 - run_at;
        if (upd_req && (m_rej == 0)) begin
          if (upd_pri == 2'd3 || upd_baud == 12'd0) begin
            nrej = 1'b1;
          end else begin
            sh_baud = int'(upd_baud); sh_stop = int'(upd_stop); sh_pri = int'(upd_pri);
            apply_at = e + Q;
            run_at = e + Q + S + 1;
          end
        end else if (win_sum >= T) begin
          go_rec = 1'b1;
          run_at = e + Q + S;
        end
        if (k % W == W - 1) win_sum = 0;
        else win_sum = win_sum + fe + pe;
      end else begin
        win_sum = 0;
      end
      m_frm = stat_clr ? 0 : sat8(m_frm + fe);
      m_par = stat_clr ? 0 : sat8(m_par + pe);
      m_rec = stat_clr ? 0 : sat8(m_rec + (go_rec ? 1 : 0));
      m_ack = nack ? 1 : 0;
      m_rej = nrej ? 1 : 0;
      pf = frm_error;
      pp = par_error;
    end
  endtask

  initial forever begin
    @(posedge line_clk);
    model_step();
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  initial forever begin
    @(negedge line_clk);
    if (m_valid) begin
      chk("tx_en", int'(cfg_tx_enable), (e >= run_at) ? 1 : 0);
      chk("rx_en", int'(cfg_rx_enable), (e >= run_at) ? 1 : 0);
      chk("busy", int'(busy), (e >= run_at) ? 0 : 1);
      chk("baud", int'(cfg_baud_16x), m_baud);
      chk("stop", int'(cfg_stop_bit), m_stop);
      chk("pri", int'(cfg_pri_mod), m_pri);
      chk("ack", int'(upd_ack), m_ack);
      chk("rej", int'(upd_rej), m_rej);
      chk("frm_cnt", int'(frm_cnt), m_frm);
      chk("par_cnt", int'(par_cnt), m_par);
      chk("recov_cnt", int'(recov_cnt), m_rec);
    end
  end

  task automatic frm_pulse();
    frm_error = 1'b1;
    @(negedge line_clk);
    frm_error = 1'b0;
    repeat (2) @(negedge line_clk);
  endtask

  initial begin
    line_reset = 1'b1; upd_req = 1'b0; upd_baud = 12'd0; upd_stop = 1'b0;
    upd_pri = 2'd0; frm_error = 1'b0; par_error = 1'b0; stat_clr = 1'b0;
    repeat (3) @(posedge line_clk);
    #1 line_reset = 1'b0;

    // Power-on settle: enables low 8 cycles, high at cycle 9.
    for (int i = 1; i <= 9; i++) begin
      @(negedge line_clk);
      chk("lit_por_en", int'(cfg_tx_enable), (i == 9) ? 1 : 0);
      chk("lit_por_busy", int'(busy), (i == 9) ? 0 : 1);
      chk("lit_por_baud", int'(cfg_baud_16x), 26);
    end

    // Valid update at cycle N.
    upd_req = 1'b1; upd_baud = 12'h104; upd_stop = 1'b1; upd_pri = 2'd2;
    for (int j = 1; j <= 14; j++) begin
      @(negedge line_clk);
      chk("lit_upd_en", int'(cfg_rx_enable), (j == 14) ? 1 : 0);
      chk("lit_upd_ack", int'(upd_ack), (j == 5) ? 1 : 0);
      chk("lit_upd_baud", int'(cfg_baud_16x), (j >= 5) ? 12'h104 : 26);
      if (j == 5) upd_req = 1'b0;
    end
    chk("lit_upd_pri", int'(cfg_pri_mod), 2);
    chk("lit_upd_stop", int'(cfg_stop_bit), 1);

    // Rejected requests: bad parity mode, then zero divisor.
    for (int r = 0; r < 2; r++) begin
      upd_req = 1'b1;
      upd_baud = (r == 0) ? 12'h050 : 12'h000;
      upd_pri = (r == 0) ? 2'd3 : 2'd1;
      upd_stop = 1'b0;
      @(negedge line_clk);
      chk("lit_rej", int'(upd_rej), 1);
      chk("lit_rej_en", int'(cfg_tx_enable), 1);
      chk("lit_rej_baud", int'(cfg_baud_16x), 12'h104);
      upd_req = 1'b0;
      @(negedge line_clk);
      chk("lit_rej_done", int'(upd_rej), 0);
      chk("lit_rej_busy", int'(busy), 0);
    end

    // Four frame-error edges in 16 cycles trigger recovery.
    repeat (3) frm_pulse();
    chk("lit_rec_pre_en", int'(cfg_tx_enable), 1);
    frm_pulse();
    chk("lit_rec_en", int'(cfg_tx_enable), 0);
    chk("lit_rec_cnt", int'(recov_cnt), 1);
    chk("lit_rec_frm", int'(frm_cnt), 4);
    chk("lit_rec_baud", int'(cfg_baud_16x), 12'h104);
    for (int i = 1; i <= 11; i++) begin
      @(negedge line_clk);
      chk("lit_rec_resume", int'(cfg_tx_enable), (i == 11) ? 1 : 0);
    end

    // Three edges, window rollover, then one edge: no recovery.
    repeat (3) frm_pulse();
    repeat (64) @(negedge line_clk);
    frm_pulse();
    chk("lit_norec_en", int'(cfg_tx_enable), 1);
    chk("lit_norec_cnt", int'(recov_cnt), 1);
    chk("lit_norec_frm", int'(frm_cnt), 8);

    // Parity counter saturation, then clear racing an increment.
    repeat (300) begin
      par_error = 1'b1;
      @(negedge line_clk);
      par_error = 1'b0;
      @(negedge line_clk);
    end
    chk("lit_par_sat", int'(par_cnt), 255);
    par_error = 1'b1;
    stat_clr = 1'b1;
    @(negedge line_clk);
    chk("lit_clr_par", int'(par_cnt), 0);
    chk("lit_clr_frm", int'(frm_cnt), 0);
    chk("lit_clr_rec", int'(recov_cnt), 0);
    par_error = 1'b0;
    stat_clr = 1'b0;

    // Reset in the middle of an update's quiesce phase.
    for (int i = 0; i < 100 && busy; i++) @(negedge line_clk);
    chk("lit_run_before_rst", int'(busy), 0);
    upd_req = 1'b1; upd_baud = 12'h0AB; upd_stop = 1'b0; upd_pri = 2'd1;
    @(negedge line_clk);
    chk("lit_rst_quiesce", int'(cfg_tx_enable), 0);
    @(negedge line_clk);
    line_reset = 1'b1;
    upd_req = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge line_clk);
      if (i == 1) line_reset = 1'b0;
      chk("lit_rst_en", int'(cfg_tx_enable), (i == 9) ? 1 : 0);
      chk("lit_rst_ack", int'(upd_ack), 0);
      chk("lit_rst_baud", int'(cfg_baud_16x), 26);
      chk("lit_rst_pri", int'(cfg_pri_mod), 0);
    end

    repeat (5) @(negedge line_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart2spi_cfg_ctrl.md
Name: uart2spi_cfg_ctrl

Overview:
Configuration sequencer for the uart2spi bridge. Drives its cfg_* inputs and loads power-on defaults after reset. Applies host reconfiguration requests safely: disable Tx/Rx, wait for quiesce, load the new values, wait for settle, then re-enable. Watches the frm_error/par_error outputs, performs automatic Rx/Tx recovery when the error rate crosses a threshold, and keeps error statistics.

Parameters:
DEF_BAUD, 12'd26, cfg_baud_16x after reset
DEF_STOP, 1'b0, cfg_stop_bit after reset
DEF_PRI, 2'd0, cfg_pri_mod after reset
QUIESCE_CYC, 16, cycles with enables low before config change (>=1)
SETTLE_CYC, 32, cycles after config load before enables rise (>=1)
ERR_THRESH, 4, error edges within one window that trigger recovery (>=1)
ERR_WINDOW, 1024, error-rate window length in cycles (>=2)

Ports:
line_clk  in  1  sole clock
line_reset  in  1  synchronous, active-high reset
upd_req  in  1  host reconfig request; held high until upd_ack or upd_rej
upd_baud  in  12  requested 16x baud divisor; stable while upd_req
upd_stop  in  1  requested stop-bit setting
upd_pri  in  2  requested parity mode
upd_ack  out  1  1-cycle pulse: request applied
upd_rej  out  1  1-cycle pulse: request rejected, config unchanged
frm_error  in  1  from uart2spi
par_error  in  1  from uart2spi
stat_clr  in  1  clears frm_cnt, par_cnt, recov_cnt
cfg_tx_enable  out  1  to uart2spi
cfg_rx_enable  out  1  to uart2spi
cfg_stop_bit  out  1  to uart2spi
cfg_pri_mod  out  2  to uart2spi
cfg_baud_16x  out  12  to uart2spi
busy  out  1  high in every state except RUN
frm_cnt  out  8  saturating count of frm_error rising edges
par_cnt  out  8  saturating count of par_error rising edges
recov_cnt  out  8  saturating count of automatic recoveries

Behaviour:
- All outputs registered.
- Reset values:
  - cfg_baud_16x=DEF_BAUD, cfg_stop_bit=DEF_STOP, cfg_pri_mod=DEF_PRI.
  - Enables 0, upd_ack/upd_rej 0, busy 1, all counters 0.
  - Error edge-detect registers 0, state SETTLE with timer 0.
- States: SETTLE, RUN, QUIESCE, APPLY.
- SETTLE:
  - Enables 0; timer counts SETTLE_CYC cycles, then go to RUN.
  - First cycle in RUN has both enables 1.
  - First RUN cycle after reset is cycle SETTLE_CYC+1 after reset deasserts.
- RUN: enables 1, busy 0. Request checked first:
  - upd_req with upd_pri==3 or upd_baud==0: upd_rej pulses next cycle; stay in RUN; host must drop upd_req within 1 cycle after upd_rej.
  - upd_req valid: capture upd_* into shadow regs, go to QUIESCE. Enables drop next cycle.
  - Otherwise, window-error count reaches ERR_THRESH: go to QUIESCE with the recovery flag set; recov_cnt increments (saturates at 255).
- QUIESCE: enables 0 for QUIESCE_CYC cycles, then:
  - Update path: go to APPLY.
  - Recovery path: go to SETTLE, cfg unchanged, no ack.
- APPLY (1 cycle): cfg regs load from shadow, upd_ack pulses in the same cycle, then go to SETTLE.
- Valid-request latency: upd_req sampled at cycle N -> upd_ack at N+1+QUIESCE_CYC -> enables rise at N+2+QUIESCE_CYC+SETTLE_CYC.
- Error monitoring:
  - Rising edge = input high and its registered value low.
  - frm_cnt/par_cnt count edges in all states, each saturating at 255.
  - Window counter and window-error count run only in RUN. Both clear on RUN entry and when the window counter reaches ERR_WINDOW-1.
  - frm and par edges in the same cycle add 2 to the window-error count.
- Simultaneous events:
  - Valid upd_req and threshold in the same RUN cycle: update wins, recov_cnt not incremented.
  - stat_clr with an increment in the same cycle: result 0.
- upd_req outside RUN is not sampled. It waits until RUN; busy indicates the wait.
- Reset mid-operation (any state): full return to reset values. A pending request is dropped with no ack/rej; the host must re-request.
- cfg_* never change while either enable is 1.

Test Plan:
- Params QUIESCE_CYC=4, SETTLE_CYC=8. Release reset -> enables 0 for 8 cycles, 1 at cycle 9; cfg_baud_16x=26, busy falls with enables.
- In RUN, upd_req baud=12'h104, stop=1, pri=2 at cycle N -> enables 0 at N+1, upd_ack and cfg change at N+5, enables 1 at N+14.
- upd_req pri=3 -> upd_rej at next cycle; cfg, enables and state unchanged. Repeat with baud=0 -> same result.
- ERR_THRESH=4, ERR_WINDOW=64. 4 frm_error pulses within 20 cycles -> enables drop, recov_cnt=1, cfg unchanged. 3 pulses then 64 idle cycles then 1 pulse -> no recovery.
- 300 par_error pulses -> par_cnt=255. stat_clr asserted with a pulse in the same cycle -> par_cnt=0.
- Assert line_reset during QUIESCE of a valid update -> no upd_ack, cfg = defaults, restart SETTLE sequence.
